// File: rtl/binary_frame_sequencer_if.sv
// Frame-buffer read port plus raster pixel stream between the sequencer and its neighbours.
// master = sequencer side; slave = memory/converter side.
interface binary_frame_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output mem_rd_en, mem_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        input  mem_rd_data, pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        output mem_rd_data, pix_ready
    );
endinterface

// File: rtl/binary_frame_sequencer.sv
// Streams one WIDTH x HEIGHT frame from a synchronous-read frame buffer as tagged raster pixels,
// hiding the one-cycle read latency behind a 2-entry prefetch FIFO.
module binary_frame_sequencer #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    output logic [15:0] frame_count_o,
    binary_frame_sequencer_if.master bus
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ADDR_W:0]  TOTAL_CNT = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W:0]  LAST_ADDR = (ADDR_W + 1)'(TOTAL - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   fetch_q;
    logic [COL_W-1:0]  col_q;
    logic              inflight_q;
    logic [2:0]        infl_tag_q;     // {sof, eol, eof} of the read in flight
    logic [10:0]       fifo_q [2];     // {sof, eol, eof, data}
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              aborted_q;
    logic [15:0]       frame_count_q;

    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              clear_s;
    logic              flush_s;
    logic [2:0]        occ_s;
    logic [10:0]       head_s;

    assign head_s          = fifo_q[rd_ptr_q];
    assign bus.pix_valid   = (cnt_q != 2'd0);
    assign bus.pix_data    = head_s[7:0];
    assign bus.pix_eof     = head_s[8];
    assign bus.pix_eol     = head_s[9];
    assign bus.pix_sof     = head_s[10];
    assign pop_s           = bus.pix_valid & bus.pix_ready;
    assign occ_s           = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign bus.mem_rd_en   = issue_s;
    assign bus.mem_addr    = fetch_q[ADDR_W-1:0];
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign aborted_o       = aborted_q;
    assign frame_count_o   = frame_count_q;

    // Next-state, read issue and FIFO push decisions.
    always_comb begin
        state_d = state_q;
        issue_s = 1'b0;
        push_s  = 1'b0;
        clear_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_RUN;
                    clear_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    flush_s = 1'b1;
                end else begin
                    push_s  = inflight_q;
                    // The slot freed by a same-cycle pop may be refilled immediately.
                    issue_s = (fetch_q < TOTAL_CNT) && ((occ_s - {2'b00, pop_s}) < 3'd2);
                    if (pop_s && head_s[8]) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, fetch counters and prefetch FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_q    <= {(ADDR_W + 1){1'b0}};
            col_q      <= {COL_W{1'b0}};
            inflight_q <= 1'b0;
            infl_tag_q <= 3'b000;
            fifo_q[0]  <= 11'd0;
            fifo_q[1]  <= 11'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else if (clear_s || flush_s) begin
            state_q    <= state_d;
            fetch_q    <= {(ADDR_W + 1){1'b0}};
            col_q      <= {COL_W{1'b0}};
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue_s;
            if (issue_s) begin
                fetch_q    <= fetch_q + (ADDR_W + 1)'(1);
                col_q      <= (col_q == LAST_COL) ? {COL_W{1'b0}} : (col_q + COL_W'(1));
                infl_tag_q <= {fetch_q == {(ADDR_W + 1){1'b0}}, col_q == LAST_COL, fetch_q == LAST_ADDR};
            end else begin
                infl_tag_q <= infl_tag_q;
            end
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {infl_tag_q, bus.mem_rd_data};
                wr_ptr_q         <= ~wr_ptr_q;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Status: abort pulse and completed-frame counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aborted_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            aborted_q <= flush_s;
            if (state_q == S_DONE) begin
                frame_count_q <= frame_count_q + 16'd1;
            end else begin
                frame_count_q <= frame_count_q;
            end
        end
    end
endmodule

// File: tb/tb_binary_frame_sequencer.sv
// Scoreboard bench for binary_frame_sequencer on a 4x3 frame with a behavioural memory model.
module tb_binary_frame_sequencer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] fc;

    binary_frame_sequencer_if #(.ADDR_W(AW)) bus ();

    binary_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .busy_o        (busy),
        .done_o        (done),
        .aborted_o     (aborted),
        .frame_count_o (fc),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mem [N];
    logic [10:0] exp_q [$];
    int          pending_done = 0;
    int          issued = 0;
    int          accepted = 0;
    int          aborted_seen = 0;
    bit          reads_allowed = 1'b0;
    logic [15:0] exp_fc = 16'd0;
    int          ready_mode = 0;
    bit          prev_stall = 1'b0;
    logic [10:0] prev_beat = 11'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Synchronous-read frame buffer
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= (bus.mem_addr < AW'(N)) ? mem[bus.mem_addr[3:0]] : 8'h00;
    end

    // pix_ready driver: 0 = manual, 1 = random 50%, 2 = always high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) bus.pix_ready = 1'($urandom % 2);
            else if (ready_mode == 2) bus.pix_ready = 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [10:0] beat;
        forever begin
            @(negedge clk);
            if (!rst) begin
                beat = {bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data};
                if (prev_stall && bus.pix_valid) check("stall_stable", beat, prev_beat);
                if (bus.pix_valid && bus.pix_ready) begin
                    accepted++;
                    if (exp_q.size() == 0) check("unexpected_beat", beat, 11'h7ff);
                    else check("beat", beat, exp_q.pop_front());
                end
                if (bus.mem_rd_en) begin
                    check("read_allowed", reads_allowed, 1);
                    check("read_addr", bus.mem_addr, issued);
                    issued++;
                    check("read_ahead", (issued - accepted) <= 2, 1);
                end
                if (done) begin
                    check("done_expected", pending_done > 0, 1);
                    check("done_after_all_beats", exp_q.size(), 0);
                    if (pending_done > 0) begin
                        pending_done--;
                        exp_fc = exp_fc + 16'd1;
                    end
                end
                if (aborted) aborted_seen++;
                prev_stall = bus.pix_valid && !bus.pix_ready;
                prev_beat  = beat;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic push_frame(input bit expect_done);
        for (int a = 0; a < N; a++)
            exp_q.push_back({a == 0, (a % W) == W - 1, a == N - 1, mem[a]});
        if (expect_done) pending_done++;
        issued        = 0;
        accepted      = 0;
        reads_allowed = 1'b1;
    endtask

    task automatic start_frame(input bit expect_done);
        push_frame(expect_done);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_fc(input string name);
        @(negedge clk);
        check(name, fc, exp_fc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_fc"}, fc, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_valid"}, bus.pix_valid, 0);
        check({tag, "_data"}, bus.pix_data, 0);
        check({tag, "_markers"}, {bus.pix_sof, bus.pix_eol, bus.pix_eof}, 0);
    endtask

    initial begin
        int first_v, done_c, idle_c;
        bit hit;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bus.pix_ready = 1'b0;
        bus.mem_rd_data = 8'h00;
        for (int a = 0; a < N; a++) mem[a] = 8'(a);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Ready held high: exact cycle timing
        ready_mode = 2;
        @(posedge clk);
        #1;
        first_v = -1; done_c = -1; idle_c = -1;
        start_frame(1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("cyc1_busy", busy, 1);
                check("cyc1_rd_en", bus.mem_rd_en, 1);
            end
            if (bus.pix_valid && first_v < 0) first_v = cyc;
            if (done && done_c < 0) done_c = cyc;
            if (!busy && done_c >= 0 && idle_c < 0) idle_c = cyc;
        end
        check("first_valid_cycle", first_v, 3);
        check("done_cycle", done_c, N + 3);
        check("idle_cycle", idle_c, N + 4);
        check("beats_accepted", accepted, N);
        @(posedge clk);
        #1;
        check_fc("fc_after_first");
        check("fc_one", fc, 1);

        // Random backpressure, random image contents
        ready_mode = 1;
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
            start_frame(1);
            wait_done(400);
            check_fc("fc_random");
        end

        // Abort after beat 5 accepted, with ready low
        for (int a = 0; a < N; a++) mem[a] = 8'(a);
        ready_mode = 0;
        bus.pix_ready = 1'b1;
        start_frame(0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (accepted == 6) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("abort_reach_beat6", hit, 1);
        bus.pix_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        reads_allowed = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_pulse", aborted, 1);
        check("abort_valid_low", bus.pix_valid, 0);
        check("abort_busy_low", busy, 0);
        @(posedge clk);
        #1 bus.pix_ready = 1'b1;
        @(negedge clk);
        check("abort_pulse_single", aborted, 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_count", aborted_seen, 1);
        check_fc("fc_after_abort");
        ready_mode = 1;
        start_frame(1);
        wait_done(400);
        check_fc("fc_after_restart");

        // start held through a whole frame
        push_frame(1);
        start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        check("held_start_done", hit, 1);
        @(posedge clk);
        #1 start = 1'b0;
        check_fc("fc_held_start");

        // start with abort in IDLE is ignored
        reads_allowed = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_rd", bus.mem_rd_en, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a frame
        start_frame(1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        pending_done  = 0;
        exp_fc        = 16'd0;
        reads_allowed = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        ready_mode = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_late_pixel", bus.pix_valid, 0);
        end
        @(posedge clk);
        #1;

        // frame_count wrap
        force dut.frame_count_q = 16'hFFFF;
        #1 release dut.frame_count_q;
        exp_fc = 16'hFFFF;
        check_fc("fc_preload");
        ready_mode = 1;
        start_frame(1);
        wait_done(400);
        check_fc("fc_wrap_model");
        check("fc_wrap_zero", fc, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        check("pending_done_zero", pending_done, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
